// File: rtl/id_operand_stage.sv
// id_operand_stage: fetch-to-decode register, register file, RAW forwarding and load-use interlock
module id_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fs_to_ds_valid,
    input  logic [31:0]       fs_inst,
    input  logic [DATA_W-1:0] fs_pc,
    output logic              ds_allowin,
    input  logic              es_allowin,
    output logic              ds_to_es_valid,
    output logic [31:0]       ds_inst,
    output logic [DATA_W-1:0] ds_pc,
    input  logic              rs_use,
    input  logic              rt_use,
    output logic [DATA_W-1:0] rs_value,
    output logic [DATA_W-1:0] rt_value,
    input  logic              flush,
    input  logic              es_valid,
    input  logic              es_wen,
    input  logic              es_load,
    input  logic [ADDR_W-1:0] es_waddr,
    input  logic [DATA_W-1:0] es_result,
    input  logic              ms_valid,
    input  logic              ms_wen,
    input  logic [ADDR_W-1:0] ms_waddr,
    input  logic [DATA_W-1:0] ms_result,
    input  logic              ws_valid,
    input  logic              ws_wen,
    input  logic [ADDR_W-1:0] ws_waddr,
    input  logic [DATA_W-1:0] ws_result,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              ds_valid;
    logic              ds_ready_go;
    logic [DATA_W-1:0] rf [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] rs_addr, rt_addr;
    logic [2:0]        rs_hit, rt_hit;
    logic              hazard_rs, hazard_rt;

    function automatic logic [2:0] hits(input logic use_src, input logic [ADDR_W-1:0] a);
        logic live;
        live = use_src && (a != '0);
        return {live & es_valid & es_wen & (es_waddr == a),
                live & ms_valid & ms_wen & (ms_waddr == a),
                live & ws_valid & ws_wen & (ws_waddr == a)};
    endfunction

    // youngest writer wins; without bypass only the committed register file is trusted
    function automatic logic [DATA_W-1:0] operand(input logic [2:0] h, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] rf_val;
        rf_val = (a == '0) ? '0 : rf[a];
        if (FWD_EN == 0) return rf_val;
        return h[2] ? es_result : h[1] ? ms_result : h[0] ? ws_result : rf_val;
    endfunction

    function automatic logic hazard(input logic [2:0] h);
        return (FWD_EN != 0) ? (h[2] & es_load) : (|h);
    endfunction

    assign rs_addr        = ds_inst[21 +: ADDR_W];
    assign rt_addr        = ds_inst[16 +: ADDR_W];
    assign rs_hit         = hits(rs_use, rs_addr);
    assign rt_hit         = hits(rt_use, rt_addr);
    assign rs_value       = operand(rs_hit, rs_addr);
    assign rt_value       = operand(rt_hit, rt_addr);
    assign hazard_rs      = hazard(rs_hit);
    assign hazard_rt      = hazard(rt_hit);
    assign ds_ready_go    = !(hazard_rs | hazard_rt);
    assign ds_allowin     = !ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go & !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (flush)
                ds_valid <= 1'b0;
            else if (ds_allowin)
                ds_valid <= fs_to_ds_valid;
            if (ds_valid && !ds_ready_go && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fs_to_ds_valid && ds_allowin) begin
            ds_inst <= fs_inst;
            ds_pc   <= fs_pc;
        end
    end

    // entry 0 may physically hold junk; reads mask it to zero
    always_ff @(posedge clk) begin
        if (ws_valid && ws_wen)
            rf[ws_waddr] <= ws_result;
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed checks of forwarding, interlocks, flush and stall counting
module tb_id_operand_stage;
    logic        clk = 0, reset = 0;
    logic        fs_to_ds_valid, es_allowin, rs_use, rt_use, flush;
    logic [31:0] fs_inst, fs_pc;
    logic        es_valid, es_wen, es_load, ms_valid, ms_wen, ws_valid, ws_wen;
    logic [4:0]  es_waddr, ms_waddr, ws_waddr;
    logic [31:0] es_result, ms_result, ws_result;

    logic        a_allowin, a_tov, n_allowin, n_tov, s_allowin, s_tov;
    logic [31:0] a_inst, a_pc, a_rs, a_rt, n_inst, n_pc, n_rs, n_rt, s_inst, s_pc, s_rs, s_rt;
    logic [15:0] a_cnt, n_cnt;
    logic [1:0]  s_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(a_allowin), .es_allowin(es_allowin), .ds_to_es_valid(a_tov), .ds_inst(a_inst),
        .ds_pc(a_pc), .rs_use(rs_use), .rt_use(rt_use), .rs_value(a_rs), .rt_value(a_rt), .flush(flush),
        .es_valid(es_valid), .es_wen(es_wen), .es_load(es_load), .es_waddr(es_waddr), .es_result(es_result),
        .ms_valid(ms_valid), .ms_wen(ms_wen), .ms_waddr(ms_waddr), .ms_result(ms_result),
        .ws_valid(ws_valid), .ws_wen(ws_wen), .ws_waddr(ws_waddr), .ws_result(ws_result), .stall_cnt(a_cnt)
    );

    id_operand_stage #(.FWD_EN(0)) dut_nf (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(n_allowin), .es_allowin(es_allowin), .ds_to_es_valid(n_tov), .ds_inst(n_inst),
        .ds_pc(n_pc), .rs_use(rs_use), .rt_use(rt_use), .rs_value(n_rs), .rt_value(n_rt), .flush(flush),
        .es_valid(es_valid), .es_wen(es_wen), .es_load(es_load), .es_waddr(es_waddr), .es_result(es_result),
        .ms_valid(ms_valid), .ms_wen(ms_wen), .ms_waddr(ms_waddr), .ms_result(ms_result),
        .ws_valid(ws_valid), .ws_wen(ws_wen), .ws_waddr(ws_waddr), .ws_result(ws_result), .stall_cnt(n_cnt)
    );

    id_operand_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
        .ds_allowin(s_allowin), .es_allowin(es_allowin), .ds_to_es_valid(s_tov), .ds_inst(s_inst),
        .ds_pc(s_pc), .rs_use(rs_use), .rt_use(rt_use), .rs_value(s_rs), .rt_value(s_rt), .flush(flush),
        .es_valid(es_valid), .es_wen(es_wen), .es_load(es_load), .es_waddr(es_waddr), .es_result(es_result),
        .ms_valid(ms_valid), .ms_wen(ms_wen), .ms_waddr(ms_waddr), .ms_result(ms_result),
        .ws_valid(ws_valid), .ws_wen(ws_wen), .ws_waddr(ws_waddr), .ws_result(ws_result), .stall_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h0, rs, rt, 16'h0};
    endfunction

    task automatic set_es(input logic v, input logic ld, input logic [4:0] a, input logic [31:0] d);
        es_valid = v; es_wen = 1; es_load = ld; es_waddr = a; es_result = d;
    endtask

    task automatic set_ms(input logic v, input logic [4:0] a, input logic [31:0] d);
        ms_valid = v; ms_wen = 1; ms_waddr = a; ms_result = d;
    endtask

    task automatic set_ws(input logic v, input logic [4:0] a, input logic [31:0] d);
        ws_valid = v; ws_wen = 1; ws_waddr = a; ws_result = d;
    endtask

    task automatic do_reset;
        fs_to_ds_valid = 0; fs_inst = 0; fs_pc = 0; es_allowin = 1; rs_use = 0; rt_use = 0; flush = 0;
        set_es(0, 0, 0, 0); set_ms(0, 0, 0); set_ws(0, 0, 0);
        reset = 1;
        tick;
        reset = 0;
    endtask

    task automatic load_inst(input logic [31:0] i, input logic [31:0] p);
        fs_to_ds_valid = 1; fs_inst = i; fs_pc = p;
        tick;
        fs_to_ds_valid = 0;
    endtask

    initial begin
        do_reset;
        #1;
        check("reset_tov", a_tov, 0);
        check("reset_allowin", a_allowin, 1);
        check("reset_cnt", a_cnt, 0);

        // forwarding priority es > ms > ws > rf
        load_inst(mk(5, 0), 32'h100);
        check("cap_inst", a_inst, mk(5, 0));
        check("cap_pc", a_pc, 32'h100);
        rs_use = 1;
        set_ws(1, 5, 32'h11); set_ms(1, 5, 32'h22); set_es(1, 0, 5, 32'h33);
        #1;
        check("fwd_es", a_rs, 32'h33);
        check("fwd_es_tov", a_tov, 1);
        check("fwd_es_allowin", a_allowin, 1);
        es_valid = 0; #1;
        check("fwd_ms", a_rs, 32'h22);
        ms_valid = 0; #1;
        check("fwd_ws", a_rs, 32'h11);
        es_allowin = 0; #1;
        check("hold_tov", a_tov, 1);
        check("hold_allowin", a_allowin, 0);
        tick;
        ws_valid = 0; #1;
        check("rf_read", a_rs, 32'h11);
        rs_use = 0; set_es(1, 0, 5, 32'h99); #1;
        check("unused_rf", a_rs, 32'h11);
        check("no_stall_cnt", a_cnt, 0);

        // load-use interlock, then MEM forwarding of the loaded value
        do_reset;
        load_inst(mk(0, 8), 32'h200);
        rt_use = 1; set_es(1, 1, 8, 32'hDEAD); #1;
        check("lu_tov", a_tov, 0);
        check("lu_allowin", a_allowin, 0);
        tick;
        check("lu_cnt", a_cnt, 1);
        es_valid = 0; set_ms(1, 8, 32'hABCD); #1;
        check("lu_rt", a_rt, 32'hABCD);
        check("lu_tov2", a_tov, 1);

        // r0 never forwards or stalls, even when physically written
        do_reset;
        load_inst(mk(0, 0), 32'h280);
        rs_use = 1; es_allowin = 0;
        set_es(1, 1, 0, 32'hFFFF); set_ws(1, 0, 32'h55); #1;
        check("r0_val", a_rs, 0);
        check("r0_tov", a_tov, 1);
        tick;
        ws_valid = 0; #1;
        check("r0_val2", a_rs, 0);

        // FWD_EN=0 waits for WB to retire
        do_reset;
        load_inst(mk(3, 0), 32'h300);
        rs_use = 1; set_ms(1, 3, 32'h77); #1;
        check("nf_tov_ms", n_tov, 0);
        check("fwd_ms_only", a_rs, 32'h77);
        tick;
        ms_valid = 0; set_ws(1, 3, 32'h77); #1;
        check("nf_cnt1", n_cnt, 1);
        check("nf_tov_ws", n_tov, 0);
        tick;
        ws_valid = 0; #1;
        check("nf_tov", n_tov, 1);
        check("nf_rs", n_rs, 32'h77);
        check("nf_cnt", n_cnt, 2);

        // flush during load-use stall
        do_reset;
        load_inst(mk(0, 8), 32'h400);
        rt_use = 1; set_es(1, 1, 8, 32'h1); flush = 1;
        fs_to_ds_valid = 1; fs_inst = mk(9, 0); fs_pc = 32'h404; #1;
        check("fl_tov", a_tov, 0);
        tick;
        flush = 0; es_valid = 0; fs_inst = mk(0, 0); fs_pc = 32'h500; #1;
        check("fl_allowin", a_allowin, 1);
        check("fl_tov2", a_tov, 0);
        tick;
        fs_to_ds_valid = 0; #1;
        check("fl_pc", a_pc, 32'h500);
        check("fl_tov3", a_tov, 1);
        check("fl_cnt", a_cnt, 1);

        // saturating counter with CNT_W=2, then reset mid-stall
        do_reset;
        load_inst(mk(0, 8), 32'h600);
        rt_use = 1; set_es(1, 1, 8, 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("sat_cnt%0d", i), s_cnt, (i < 3) ? i + 1 : 3);
        end
        reset = 1;
        tick;
        reset = 0; #1;
        check("sat_rst_cnt", s_cnt, 0);
        check("sat_rst_allowin", s_allowin, 1);
        check("sat_rst_tov", s_tov, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
